// File: rtl/axis_uart_rx_if.sv
// axis_uart_rx_if: AXI-Stream data/valid/ready bundle carrying received words
interface axis_uart_rx_if #(parameter int W = 32);
  logic [W-1:0] tdata;
  logic tvalid;
  logic tready;
  modport master (output tdata, tvalid, input tready);
  modport slave (input tdata, tvalid, output tready);
endinterface

// File: rtl/axis_uart_rx.sv
// axis_uart_rx: UART receiver packing DATA_BYTE frames (first frame = MSB) into one AXI-Stream word
module axis_uart_rx #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int CLOCK = 100_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY_BITS = 0
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic uart_rx,
  output logic rx_done,
  output logic rx_parity_err,
  output logic rx_frame_err,
  output logic rx_overrun,
  axis_uart_rx_if.master m_axis
);
  localparam int COUNT_SPEED = CLOCK / BAUD_RATE;
  localparam int HALF = COUNT_SPEED / 2;
  localparam int DATA_BYTE = AXI_DATA_WIDTH / DATA_BITS;
  localparam int CW = $clog2(COUNT_SPEED);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam int IW = $clog2(DATA_BYTE) + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic [AXI_DATA_WIDTH-1:0] word_q, word_d, tdata_q, tdata_d;
  logic perr_q, perr_d, stop_bad_q, stop_bad_d, deliver_q, deliver_d;
  logic tvalid_q, tvalid_d, done_q, done_d, perr_out_q, perr_out_d;
  logic fe_q, fe_d, ov_q, ov_d;
  logic rx_s, bit_tick, half_tick;
  assign rx_s = sync_q[1];
  assign bit_tick = cnt_q == CW'(COUNT_SPEED - 1);
  assign half_tick = cnt_q == CW'(HALF - 1);
  assign m_axis.tdata = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign rx_done = done_q;
  assign rx_parity_err = perr_out_q;
  assign rx_frame_err = fe_q;
  assign rx_overrun = ov_q;
  // Next-state: synchroniser, frame FSM, word assembly and output register handoff
  always_comb begin
    sync_d = {sync_q[0], uart_rx};
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    idx_d = idx_q;
    byte_d = byte_q;
    word_d = word_q;
    perr_d = perr_q;
    stop_bad_d = stop_bad_q;
    deliver_d = 1'b0;
    fe_d = 1'b0;
    ov_d = 1'b0;
    done_d = 1'b0;
    perr_out_d = 1'b0;
    tdata_d = tdata_q;
    tvalid_d = tvalid_q && !m_axis.tready;
    if (deliver_q) begin
      if (!tvalid_q || m_axis.tready) begin
        tdata_d = word_q;
        tvalid_d = 1'b1;
        done_d = 1'b1;
        perr_out_d = perr_q;
      end else begin
        ov_d = 1'b1;
      end
      word_d = '0;
      perr_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d = '0;
        end
      end
      START: begin
        if (half_tick) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_tick) begin
          cnt_d = '0;
          byte_d = {rx_s, byte_q[DATA_BITS-1:1]};
          bit_d = bit_q + BW'(1);
          if (bit_q == BW'(DATA_BITS - 1)) state_d = PARITY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        if (bit_tick) begin
          cnt_d = '0;
          bit_d = '0;
          stop_bad_d = 1'b0;
          state_d = STOP;
          if (rx_s != ((PARITY_BITS != 0) ? ^byte_q : ~^byte_q)) perr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          bit_d = bit_q + BW'(1);
          stop_bad_d = stop_bad_q | ~rx_s;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            state_d = IDLE;
            if (stop_bad_d) begin
              fe_d = 1'b1;
              idx_d = '0;
              perr_d = 1'b0;
              word_d = '0;
            end else begin
              word_d = {word_q[AXI_DATA_WIDTH-DATA_BITS-1:0], byte_q};
              deliver_d = idx_q == IW'(DATA_BYTE - 1);
              idx_d = deliver_d ? '0 : idx_q + IW'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      sync_q <= 2'b11;
      cnt_q <= '0;
      bit_q <= '0;
      idx_q <= '0;
      byte_q <= '0;
      word_q <= '0;
      perr_q <= 1'b0;
      stop_bad_q <= 1'b0;
      deliver_q <= 1'b0;
      tdata_q <= '0;
      tvalid_q <= 1'b0;
      done_q <= 1'b0;
      perr_out_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      idx_q <= idx_d;
      byte_q <= byte_d;
      word_q <= word_d;
      perr_q <= perr_d;
      stop_bad_q <= stop_bad_d;
      deliver_q <= deliver_d;
      tdata_q <= tdata_d;
      tvalid_q <= tvalid_d;
      done_q <= done_d;
      perr_out_q <= perr_out_d;
      fe_q <= fe_d;
      ov_q <= ov_d;
    end
  end
endmodule
